gamepad_responder: RTL and testbench
====================================

GAMEPAD_RESPONDER -- requirements
Module: gamepad_responder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 150000; number of clk cycles without a select edge before the phase counter resynchronises (1.5 ms at 100 MHz).
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 select  input  1  select (TH) line driven by the host reader; asynchronous to clk.
REQ-005 btn_in  input  12  pressed-high button state, synchronous to clk; bits [0]Up [1]Down [2]Left [3]Right [4]A [5]B [6]C [7]X [8]Y [9]Z [10]Start [11]Mode.
REQ-006 pin_1, pin_2, pin_3, pin_4, pin_6, pin_9  output  1 each  active-low controller data lines (0 = pressed or forced low).
REQ-007 phase  output  3  current protocol phase index p (debug/status).
REQ-008 frame_pulse  output  1  one-cycle pulse when p wraps from 7 to 0.

Function
REQ-009 select shall pass through a 2-flop synchroniser; the edge detector shall compare the second flop with a third, registered copy.
REQ-010 Each detected edge of the synchronised select, rising or falling, shall advance p by 1, modulo 8; 7->0 shall assert frame_pulse for exactly one cycle.
REQ-011 A timeout counter shall clear on every detected edge, otherwise increment, saturating at TIMEOUT_CYCLES.
REQ-012 While the timeout counter equals TIMEOUT_CYCLES, p shall be forced every cycle to 0 if synchronised select = 1, else to 1; no frame_pulse.
REQ-013 Same cycle edge and saturation: edge wins (p advances, counter clears).
REQ-014 Pin map, registered from p and btn_in (~x = inverted button):
- p=0,2,4: pin_1..4 = ~Up ~Down ~Left ~Right; pin_6 = ~B; pin_9 = ~C.
- p=1,3: pin_1 = ~Up; pin_2 = ~Down; pin_3 = pin_4 = 0; pin_6 = ~A; pin_9 = ~Start.
- p=5: pin_1..4 = 0; pin_6 = ~A; pin_9 = ~Start.
- p=6: pin_1 = ~Z; pin_2 = ~Y; pin_3 = ~X; pin_4 = ~Mode; pin_6 = ~B; pin_9 = ~C.
- p=7: pin_1..4 = 1; pin_6 = ~A; pin_9 = ~Start.
REQ-015 Latency: edge on select -> p updated 3 cycles later -> pins valid 4 cycles later; btn_in change -> pins 1 cycle later.
REQ-016 All outputs shall be registered; no combinational path from inputs to outputs.
REQ-017 The timeout counter shall be wide enough for TIMEOUT_CYCLES without overflow.

Reset
REQ-018 On rst: synchroniser and edge flops = 1, p = 0, timeout counter = 0, frame_pulse = 0, all pins = 1.
REQ-019 rst asserted mid-frame shall abandon the frame; the first edge after release shall be evaluated against the reset flop value of 1.
REQ-020 After rst release, pins reflect the p=0 map of btn_in from the next cycle.

Verification
REQ-021 Idle, btn_in = 12'h000, select = 1: all pins = 1, phase = 0 -> after reset, with no frame_pulse.
REQ-022 btn_in = Up|A|Start (12'h411), select falls once: p = 1, pin_1 = 0, pin_2 = 1, pin_3 = pin_4 = 0, pin_6 = 0, pin_9 = 0, 4 cycles after the edge.
REQ-023 Full 8-edge frame with 1000-cycle phases, btn_in = X|Mode (12'h880): at p=6, pin_3 = 0, pin_4 = 0, pin_1 = pin_2 = 1; at p=5, pins 1-4 = 0; one frame_pulse after the 8th edge, phase = 0.
REQ-024 Three edges, then select held low 150000 cycles (TIMEOUT_CYCLES): phase = 1 once the counter saturates; raise select -> phase = 2, and three further edges -> phase = 5.
REQ-025 Reset asserted at p=4, then released with select = 1: phase = 0, pins = 1 with btn_in = 0; next falling edge -> phase = 1.
REQ-026 1-cycle glitch on select, which yields 2 edges: phase advances by 2; a subsequent timeout restores phase = 0.

Source files
------------

// File: rtl/gamepad_responder.sv
`default_nettype none
// ============================================================================
// Module      : gamepad_responder
// Description : Six-button gamepad responder. Tracks the host's select (TH)
//               toggles as an eight-step protocol phase and presents the
//               button state multiplexed onto six active-low data pins for
//               the current phase. A long gap in select activity
//               resynchronises the phase to the select level.
// Ports       : clk          - system clock, rising edge
//               rst          - synchronous active-high reset
//               select       - host select line (asynchronous to clk)
//               btn_in[11:0] - pressed-high buttons: 0 Up, 1 Down, 2 Left,
//                              3 Right, 4 A, 5 B, 6 C, 7 X, 8 Y, 9 Z,
//                              10 Start, 11 Mode
//               pin_1..pin_4, pin_6, pin_9 - active-low data lines
//               phase[2:0]   - current protocol phase
//               frame_pulse  - one-cycle pulse when phase wraps 7 -> 0
// Revision    : 1.0 - initial release
// ============================================================================
module gamepad_responder #(
    parameter int TIMEOUT_CYCLES = 150000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        select,
    input  logic [11:0] btn_in,
    output logic        pin_1,
    output logic        pin_2,
    output logic        pin_3,
    output logic        pin_4,
    output logic        pin_6,
    output logic        pin_9,
    output logic [2:0]  phase,
    output logic        frame_pulse
);

    localparam int            CW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] C_TMAX = CW'(TIMEOUT_CYCLES);

    // Synchroniser (sync1/sync2) plus a delayed copy (sync3) for edge detect.
    logic          sync1_q, sync2_q, sync3_q;
    logic [2:0]    phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fp_q, fp_d;
    // Pin vector order: {pin_9, pin_6, pin_4, pin_3, pin_2, pin_1}
    logic [5:0]    pins_q, pins_d;
    logic          w_edge;
    logic          w_sat;

    assign w_edge = sync2_q ^ sync3_q;
    assign w_sat  = (cnt_q == C_TMAX);

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        fp_d    = 1'b0;
        if (w_edge) begin
            // An edge takes priority over a saturated timeout.
            phase_d = phase_q + 3'd1;
            cnt_d   = '0;
            fp_d    = (phase_q == 3'd7);
        end else if (w_sat) begin
            // Idle line: select high means the host is at the start of a
            // frame (phase 0); select low means it has just begun one.
            phase_d = sync2_q ? 3'd0 : 3'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Pins follow the registered phase, so a select edge reaches the pins one
    // cycle after the phase changes while a button change takes one cycle.
    always_comb begin
        pins_d = 6'h3F;
        case (phase_q)
            3'd0, 3'd2, 3'd4: pins_d = {~btn_in[6],  ~btn_in[5], ~btn_in[3],
                                        ~btn_in[2],  ~btn_in[1], ~btn_in[0]};
            3'd1, 3'd3:       pins_d = {~btn_in[10], ~btn_in[4], 2'b00,
                                        ~btn_in[1],  ~btn_in[0]};
            3'd5:             pins_d = {~btn_in[10], ~btn_in[4], 4'b0000};
            3'd6:             pins_d = {~btn_in[6],  ~btn_in[5], ~btn_in[11],
                                        ~btn_in[7],  ~btn_in[8], ~btn_in[9]};
            default:          pins_d = {~btn_in[10], ~btn_in[4], 4'b1111};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
            phase_q <= 3'd0;
            cnt_q   <= '0;
            fp_q    <= 1'b0;
            pins_q  <= 6'h3F;
        end else begin
            sync1_q <= select;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            fp_q    <= fp_d;
            pins_q  <= pins_d;
        end
    end

    assign pin_1       = pins_q[0];
    assign pin_2       = pins_q[1];
    assign pin_3       = pins_q[2];
    assign pin_4       = pins_q[3];
    assign pin_6       = pins_q[4];
    assign pin_9       = pins_q[5];
    assign phase       = phase_q;
    assign frame_pulse = fp_q;

endmodule
`default_nettype wire

// File: tb/tb_gamepad_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_gamepad_responder
// Description : Scoreboard bench for gamepad_responder. Stimulus schedules
//               expected phase / pin / frame-pulse-count values for specific
//               cycles; a monitor compares them against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gamepad_responder;

    localparam int T = 2000;

    logic        clk = 1'b0;
    logic        rst;
    logic        select;
    logic [11:0] btn_in;
    logic        pin_1, pin_2, pin_3, pin_4, pin_6, pin_9;
    logic [2:0]  phase;
    logic        frame_pulse;
    logic [5:0]  pins_v;

    assign pins_v = {pin_9, pin_6, pin_4, pin_3, pin_2, pin_1};

    gamepad_responder #(.TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .rst         (rst),
        .select      (select),
        .btn_in      (btn_in),
        .pin_1       (pin_1),
        .pin_2       (pin_2),
        .pin_3       (pin_3),
        .pin_4       (pin_4),
        .pin_6       (pin_6),
        .pin_9       (pin_9),
        .phase       (phase),
        .frame_pulse (frame_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        string      tag;
        logic [2:0] ph;
        logic [5:0] pins;
        int         fpc;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   fpc   = 0;

    // Hand-computed pin vectors for btn_in = X|Mode, indexed by phase.
    logic [5:0] exp_880 [8] = '{6'h3F, 6'h33, 6'h3F, 6'h33,
                                6'h3F, 6'h30, 6'h33, 6'h3F};

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: counts frame pulses since reset, checks due scoreboard entries.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) fpc = 0;
            else if (frame_pulse === 1'b1) fpc++;
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                n_chk++;
                if (e.at != cyc)
                    $display("FAIL %s: not sampled at cycle %0d (now %0d)", e.tag, e.at, cyc);
                else if (phase === e.ph && pins_v === e.pins && fpc == e.fpc)
                    n_pass++;
                else
                    $display("FAIL %s: got phase=%0d pins=%b pulses=%0d, expected phase=%0d pins=%b pulses=%0d",
                             e.tag, phase, pins_v, fpc, e.ph, e.pins, e.fpc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int d, input string tag, input logic [2:0] ph,
                             input logic [5:0] p, input int f);
        exp_t e;
        e.at = cyc + d; e.tag = tag; e.ph = ph; e.pins = p; e.fpc = f;
        sb.push_back(e);
    endtask

    task automatic do_reset(input logic s, input logic [11:0] b);
        rst = 1'b1; select = s; btn_in = b;
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    initial begin
        rst = 1'b1; select = 1'b1; btn_in = 12'h000;
        tick(3);
        expect_at(0, "reset_state", 3'd0, 6'h3F, 0);
        tick(1);
        rst = 1'b0;
        expect_at(1,  "idle_after_reset", 3'd0, 6'h3F, 0);
        expect_at(40, "idle_no_pulse",    3'd0, 6'h3F, 0);
        tick(40);

        // Single falling edge with Up|A|Start held.
        btn_in = 12'h411;
        expect_at(0, "btn_not_yet",    3'd0, 6'h3F, 0);
        expect_at(1, "btn_to_pins_p0", 3'd0, 6'h3E, 0);
        tick(2);
        select = 1'b0;
        expect_at(2, "fall_phase_not_yet", 3'd0, 6'h3E, 0);
        expect_at(3, "fall_phase_lat3",    3'd1, 6'h3E, 0);
        expect_at(4, "fall_pins_lat4",     3'd1, 6'h02, 0);
        tick(10);
        btn_in = 12'h000;
        expect_at(1, "btn_release_p1", 3'd1, 6'h33, 0);
        tick(5);

        // Full frame, 1000-cycle phases, X|Mode held.
        do_reset(1'b1, 12'h880);
        for (int k = 1; k <= 8; k++) begin
            select = ~select;
            expect_at(4, $sformatf("frame_edge%0d", k), 3'(k % 8), exp_880[k % 8], (k == 8) ? 1 : 0);
            tick(1000);
        end
        expect_at(0, "frame_single_pulse", 3'd0, 6'h3F, 1);
        tick(1);

        // Timeout resynchronisation with select held low.
        do_reset(1'b1, 12'h000);
        for (int k = 0; k < 3; k++) begin
            select = ~select;
            tick(20);
        end
        expect_at(T - 17, "pre_timeout_phase3", 3'd3, 6'h33, 0);
        expect_at(T - 16, "timeout_force_p1",   3'd1, 6'h33, 0);
        expect_at(T + 50, "timeout_held_p1",    3'd1, 6'h33, 0);
        tick(T + 60);
        select = 1'b1;
        expect_at(4, "edge_beats_timeout", 3'd2, 6'h3F, 0);
        tick(20);
        for (int k = 0; k < 3; k++) begin
            select = ~select;
            tick(20);
        end
        expect_at(0, "resume_to_p5", 3'd5, 6'h30, 0);
        tick(1);

        // Reset mid-frame.
        do_reset(1'b1, 12'h000);
        for (int k = 0; k < 4; k++) begin
            select = ~select;
            tick(20);
        end
        btn_in = 12'h411;
        tick(2);
        expect_at(0, "p4_before_reset", 3'd4, 6'h3E, 0);
        tick(1);
        rst = 1'b1;
        tick(2);
        expect_at(0, "reset_mid_frame", 3'd0, 6'h3F, 0);
        btn_in = 12'h000;
        tick(1);
        rst = 1'b0;
        expect_at(1,  "release_p0",       3'd0, 6'h3F, 0);
        expect_at(30, "release_stays_p0", 3'd0, 6'h3F, 0);
        tick(30);
        select = 1'b0;
        expect_at(4, "first_fall_after_reset", 3'd1, 6'h33, 0);
        tick(20);

        // Release with select low: counts as an edge against the reset value.
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        expect_at(2, "release_low_no_edge_yet", 3'd0, 6'h3F, 0);
        expect_at(3, "release_low_edge",        3'd1, 6'h3F, 0);
        tick(20);

        // One-cycle glitch gives two edges; timeout then restores phase 0.
        do_reset(1'b1, 12'h000);
        tick(20);
        select = 1'b0;
        tick(1);
        select = 1'b1;
        expect_at(2,      "glitch_first_edge",      3'd1, 6'h3F, 0);
        expect_at(5,      "glitch_two_edges",       3'd2, 6'h3F, 0);
        expect_at(T + 10, "glitch_timeout_restore", 3'd0, 6'h3F, 0);
        tick(T + 20);

        for (int i = 0; i < 100 && sb.size() > 0; i++) tick(1);
        if (sb.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d scoreboard entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
